rf_wb_arbiter: RTL and testbench

Shares the single register-file write port between two producers: the ALU writeback stream (R_TYPE/I_TYPE results) and the load-return path (LOAD data from memory, variable latency). ALU results are buffered in a small fall-through FIFO so the ALU stage stalls rather than losing writes. Loads are flow-controlled with valid/ready. A starvation counter bounds the wait of either side. Outputs drive writeAddr_RF_WB / writeData_RF_WB / writeEn_RF_WB into the register file.

---
 rtl/rf_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU results (via fall-through FIFO) vs load returns, one registered write per cycle.
// Optional conflict statistics counter enabled by RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
  parameter int RF_DEPTH   = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                            clk_100MHz,
  input  logic                            reset,
  input  logic                            alu_valid,
  input  logic [4:0]                      alu_rd,
  input  logic [31:0]                     alu_data,
  output logic                            alu_stall,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [4:0]                      ld_rd,
  input  logic [31:0]                     ld_data,
  output logic [$clog2(RF_DEPTH<<2)-1:0]  writeAddr_RF_WB,
  output logic [31:0]                     writeData_RF_WB,
  output logic                            writeEn_RF_WB,
  output logic                            err_ovf,
  output logic [31:0]                     conflict_cnt
);

  localparam int AW = $clog2(RF_DEPTH << 2);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] alu_starve, ld_starve;

  logic          fifo_empty, fifo_full;
  logic          alu_pend;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          grant_alu, grant_ld;
  logic          pop, bypass, push, ovf;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic          win_we;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign alu_pend   = !fifo_empty || alu_valid;
  assign head_rd    = fifo_empty ? alu_rd   : fifo_rd[rd_ptr];
  assign head_data  = fifo_empty ? alu_data : fifo_data[rd_ptr];

  // Same-rd collisions go to the load: it is older in program order.
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (alu_pend && ld_valid) begin
      if (head_rd == ld_rd && ld_rd != 5'd0) grant_ld  = 1'b1;
      else if (alu_starve == SMAX)           grant_alu = 1'b1;
      else if (ld_starve == SMAX)            grant_ld  = 1'b1;
      else                                   grant_alu = 1'b1;
    end else if (alu_pend) begin
      grant_alu = 1'b1;
    end else if (ld_valid) begin
      grant_ld = 1'b1;
    end
  end

  assign pop    = grant_alu && !fifo_empty;
  assign bypass = grant_alu && fifo_empty;
  assign push   = alu_valid && !bypass && (!fifo_full || pop);
  assign ovf    = alu_valid && fifo_full && !pop;

  assign win_rd   = grant_ld ? ld_rd   : head_rd;
  assign win_data = grant_ld ? ld_data : head_data;
  assign win_we   = (grant_alu || grant_ld) && (win_rd != 5'd0);

  assign alu_stall = fifo_full;
  assign ld_ready  = reset && (grant_ld || !ld_valid);

  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A requester with nothing pending forgets its losing streak.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      alu_starve <= '0;
      ld_starve  <= '0;
    end else begin
      if (!alu_pend || grant_alu)  alu_starve <= '0;
      else if (alu_starve != SMAX) alu_starve <= alu_starve + 1'b1;
      if (!ld_valid || grant_ld)   ld_starve <= '0;
      else if (ld_starve != SMAX)  ld_starve <= ld_starve + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      writeEn_RF_WB   <= 1'b0;
      writeAddr_RF_WB <= '0;
      writeData_RF_WB <= '0;
      err_ovf         <= 1'b0;
    end else begin
      writeEn_RF_WB   <= win_we;
      writeAddr_RF_WB <= win_we ? AW'({win_rd, 2'b00}) : '0;
      writeData_RF_WB <= win_we ? win_data : 32'd0;
      if (ovf) err_ovf <= 1'b1;
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [31:0] conflict_q;
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset)                    conflict_q <= 32'd0;
    else if (alu_pend && ld_valid) conflict_q <= conflict_q + 32'd1;
  end
  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int SMAX  = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 7;
`ifdef RF_WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid;
  logic [4:0]    alu_rd, ld_rd;
  logic [31:0]   alu_data, ld_data;
  logic          alu_stall, ld_ready, writeEn_RF_WB, err_ovf;
  logic [AW-1:0] writeAddr_RF_WB;
  logic [31:0]   writeData_RF_WB, conflict_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.RF_DEPTH(32), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk_100MHz(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .writeAddr_RF_WB(writeAddr_RF_WB), .writeData_RF_WB(writeData_RF_WB),
    .writeEn_RF_WB(writeEn_RF_WB), .err_ovf(err_ovf), .conflict_cnt(conflict_cnt)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; } exp_t;

  ent_t aq[$];
  exp_t eq[$];
  int   as_m, ls_m, conf_m;
  bit   err_m, last_ld_win, last_ready;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    aq.delete();
    eq.delete();
    as_m = 0; ls_m = 0; conf_m = 0;
    err_m = 1'b0; last_ld_win = 1'b0;
  endtask

  // One cycle: called at a negedge, returns at the following negedge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    ent_t head;
    bit   ap, aw, lw, consumed, exp_ready, exp_stall;
    chk("err_ovf", err_ovf, err_m);
    chk("conflict_cnt", conflict_cnt, STATS ? conf_m : 0);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;

    ap   = (aq.size() > 0) || av;
    head = (aq.size() > 0) ? aq[0] : '{rd: ard, data: adat};
    aw = 1'b0; lw = 1'b0;
    if (ap && lv) begin
      conf_m++;
      if (head.rd == lrd && lrd != 0) lw = 1'b1;
      else if (as_m == SMAX)          aw = 1'b1;
      else if (ls_m == SMAX)          lw = 1'b1;
      else                            aw = 1'b1;
    end else begin
      aw = ap;
      lw = lv;
    end
    exp_ready = lw || !lv;
    exp_stall = (aq.size() == DEPTH);

    #1;
    last_ready = ld_ready;
    chk("ld_ready", ld_ready, exp_ready);
    chk("alu_stall", alu_stall, exp_stall);

    if (aw && head.rd != 0) eq.push_back('{cyc: cyc + 1, addr: AW'(head.rd) << 2, data: head.data});
    if (lw && lrd != 0)     eq.push_back('{cyc: cyc + 1, addr: AW'(lrd) << 2, data: ldat});

    as_m = (!ap || aw) ? 0 : ((as_m < SMAX) ? as_m + 1 : SMAX);
    ls_m = (!lv || lw) ? 0 : ((ls_m < SMAX) ? ls_m + 1 : SMAX);

    consumed = aw && (aq.size() == 0);
    if (aw && aq.size() > 0) void'(aq.pop_front());
    if (av && !consumed) begin
      if (aq.size() < DEPTH) aq.push_back('{rd: ard, data: adat});
      else                   err_m = 1'b1;
    end
    last_ld_win = lw;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor: samples just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        chk("wen_in_reset", writeEn_RF_WB, 0);
      end else if (writeEn_RF_WB) begin
        if (eq.size() == 0) begin
          chk("wr_unexpected", writeEn_RF_WB, 0);
        end else begin
          e = eq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", writeAddr_RF_WB, e.addr);
          chk("wr_data", writeData_RF_WB, e.data);
        end
      end else begin
        chk("idle_addr", writeAddr_RF_WB, 0);
        chk("idle_data", writeData_RF_WB, 0);
        if (eq.size() > 0 && eq[0].cyc <= cyc) begin
          chk("wr_missing", writeEn_RF_WB, 1);
          void'(eq.pop_front());
        end
      end
    end
  end

  initial begin
    logic        lv_c;
    logic [4:0]  lrd_c;
    logic [31:0] ldat_c;
    bit          av_r;

    model_clear();
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hDEAD_BEEF;
    ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'hCAFE_0000;
    @(negedge clk); @(negedge clk);
    chk("rst_wen", writeEn_RF_WB, 0);
    chk("rst_addr", writeAddr_RF_WB, 0);
    chk("rst_data", writeData_RF_WB, 0);
    chk("rst_err", err_ovf, 0);
    chk("rst_conf", conflict_cnt, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_stall", alu_stall, 0);
    alu_valid = 1'b0; ld_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Solo ALU write
    step(1, 5'd3, 32'h1234, 0, 0, 0);
    chk("solo_wen", writeEn_RF_WB, 1);
    chk("solo_addr", writeAddr_RF_WB, 7'h0C);
    chk("solo_data", writeData_RF_WB, 32'h1234);
    idle(2);

    // Different-rd collision: ALU x4 then LD, repeating
    for (int i = 0; i < 20; i++) begin
      step(aq.size() < DEPTH, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i);
      chk("coll_ready_pattern", last_ready, (i % 5) == 4);
    end
    idle(4);

    // Same-rd ordering
    step(1, 5'd7, 32'h22, 1, 5'd7, 32'h11);
    chk("same_addr0", writeAddr_RF_WB, 7'h1C);
    chk("same_data0", writeData_RF_WB, 32'h11);
    step(0, 0, 0, 0, 0, 0);
    chk("same_addr1", writeAddr_RF_WB, 7'h1C);
    chk("same_data1", writeData_RF_WB, 32'h22);
    idle(2);

    // x0 write is consumed silently
    step(1, 5'd0, 32'h5555, 0, 0, 0);
    chk("x0_wen", writeEn_RF_WB, 0);
    step(0, 0, 0, 1, 5'd0, 32'h6666);
    chk("x0_ld_wen", writeEn_RF_WB, 0);
    idle(1);

    // Overflow: loads keep winning on the same rd, FIFO fills, then one more ALU write
    for (int i = 0; i < 3; i++) step(1, 5'd9, 32'hA00 + i, 1, 5'd9, 32'hB00 + i);
    chk("ovf_set", err_ovf, 1);
    step(0, 0, 0, 1, 5'd9, 32'hB10);
    chk("ovf_sticky", err_ovf, 1);

    // Reset mid-write with the FIFO still holding entries
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5_0001;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h77;
    reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_ld_ready", ld_ready, 0);
    chk("mid_rst_stall", alu_stall, 0);
    @(negedge clk);
    chk("mid_rst_wen", writeEn_RF_WB, 0);
    chk("mid_rst_addr", writeAddr_RF_WB, 0);
    chk("mid_rst_data", writeData_RF_WB, 0);
    chk("mid_rst_err", err_ovf, 0);
    alu_valid = 1'b0; ld_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    idle(2);

    // Conflict statistics: ten cycles with both sides pending
    for (int i = 0; i < 10; i++) step(aq.size() < DEPTH, 5'd1, 32'h300 + i, 1, 5'd2, 32'h400 + i);
    chk("stats_10", conflict_cnt, STATS ? 32'd10 : 32'd0);
    idle(4);

    // Randomized traffic with held load requests
    lv_c = 1'b0; lrd_c = '0; ldat_c = '0;
    for (int i = 0; i < 800; i++) begin
      if (!lv_c || last_ld_win) begin
        lv_c   = ($urandom_range(0, 99) < 55);
        lrd_c  = 5'($urandom_range(0, 7));
        ldat_c = $urandom;
      end
      av_r = (aq.size() < DEPTH) && ($urandom_range(0, 99) < 60);
      step(av_r, 5'($urandom_range(0, 7)), $urandom, lv_c, lrd_c, ldat_c);
    end
    idle(6);
    chk("sb_drained", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
